// File: rtl/verifica_numero.sv
// Sudoku rule check for a candidate digit: scans row, column and 3x3 block one cell per clock,
// then reports valid / conflict / input error and, when valid, presents the board with the digit written in.
module verifica_numero #(
    parameter int N_CELAS = 81,
    parameter int W_CELA  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [3:0]                    regLinha,
    input  logic [3:0]                    regColuna,
    input  logic [3:0]                    regNumero,
    input  logic [0:N_CELAS*W_CELA-1]     sudokuJogador,
    output logic [1:0]                    saidaNumero,
    output logic [2:0]                    conflitos,
    output logic                          ocupado,
    output logic [0:N_CELAS*W_CELA-1]     sudokuAtualizado
);

    localparam int W_BUS = N_CELAS * W_CELA;

    typedef enum logic [2:0] {
        OCIOSO,
        VARRE_LIN,
        VARRE_COL,
        VARRE_BLOCO,
        FIM
    } estado_t;

    estado_t            estado, estado_n;
    logic [3:0]         k, k_n;
    logic [3:0]         lin_q, lin_n, col_q, col_n, num_q, num_n;
    logic [0:W_BUS-1]   tab_q, tab_n;
    logic [1:0]         saida_n;
    logic [2:0]         conf_n;
    logic               ocup_n;
    logic [0:W_BUS-1]   atual_n;

    logic [3:0]         scan_l, scan_c, bloco_l, bloco_c;
    logic [W_CELA-1:0]  valor;
    logic               alvo;

    // Row/column widened to 9 bits before the multiply; (9,9) lands on bit 320.
    function automatic logic [8:0] indice(input logic [3:0] l, input logic [3:0] c);
        logic [8:0] lx, cx;
        lx = {5'd0, l};
        cx = {5'd0, c};
        return ((lx - 9'd1) * 9'd9 + (cx - 9'd1)) * 9'd4;
    endfunction

    function automatic logic fora(input logic [3:0] v);
        return (v == 4'd0) || (v > 4'd9);
    endfunction

    always_comb begin
        bloco_l = ((lin_q - 4'd1) / 4'd3) * 4'd3 + 4'd1;
        bloco_c = ((col_q - 4'd1) / 4'd3) * 4'd3 + 4'd1;
        scan_l  = 4'd1;
        scan_c  = 4'd1;
        case (estado)
            VARRE_LIN: begin
                scan_l = lin_q;
                scan_c = k + 4'd1;
            end
            VARRE_COL: begin
                scan_l = k + 4'd1;
                scan_c = col_q;
            end
            VARRE_BLOCO: begin
                scan_l = bloco_l + k / 4'd3;
                scan_c = bloco_c + k % 4'd3;
            end
            default: ;
        endcase
        valor = tab_q[indice(scan_l, scan_c) +: W_CELA];
        alvo  = (scan_l == lin_q) && (scan_c == col_q);
    end

    always_comb begin
        estado_n = estado;
        k_n      = k;
        lin_n    = lin_q;
        col_n    = col_q;
        num_n    = num_q;
        tab_n    = tab_q;
        saida_n  = saidaNumero;
        conf_n   = conflitos;
        ocup_n   = ocupado;
        atual_n  = sudokuAtualizado;

        case (estado)
            OCIOSO: begin
                if (enable) begin
                    lin_n = regLinha;
                    col_n = regColuna;
                    num_n = regNumero;
                    tab_n = sudokuJogador;
                    // Range test precedes the cell lookup so an out-of-range index is never used.
                    if (fora(regLinha) || fora(regColuna) || fora(regNumero)) begin
                        estado_n = FIM;
                        saida_n  = 2'b01;
                        conf_n   = '0;
                    end else if (sudokuJogador[indice(regLinha, regColuna) +: W_CELA] != '0) begin
                        estado_n = FIM;
                        saida_n  = 2'b01;
                        conf_n   = '0;
                    end else begin
                        estado_n = VARRE_LIN;
                        k_n      = '0;
                        ocup_n   = 1'b1;
                        saida_n  = 2'b00;
                        conf_n   = '0;
                    end
                end
            end

            VARRE_LIN, VARRE_COL, VARRE_BLOCO: begin
                if (!enable) begin
                    estado_n = OCIOSO;
                    k_n      = '0;
                    ocup_n   = 1'b0;
                    saida_n  = 2'b00;
                    conf_n   = '0;
                end else begin
                    if (!alvo && valor == num_q) begin
                        case (estado)
                            VARRE_LIN: conf_n[2] = 1'b1;
                            VARRE_COL: conf_n[1] = 1'b1;
                            default:   conf_n[0] = 1'b1;
                        endcase
                    end
                    if (k == 4'd8) begin
                        k_n = '0;
                        case (estado)
                            VARRE_LIN: estado_n = VARRE_COL;
                            VARRE_COL: estado_n = VARRE_BLOCO;
                            default: begin
                                estado_n = FIM;
                                ocup_n   = 1'b0;
                                if (conf_n == 3'b000) begin
                                    saida_n = 2'b11;
                                    atual_n = tab_q;
                                    atual_n[indice(lin_q, col_q) +: W_CELA] = num_q;
                                end else begin
                                    saida_n = 2'b10;
                                end
                            end
                        endcase
                    end else begin
                        k_n = k + 4'd1;
                    end
                end
            end

            FIM: begin
                if (!enable) begin
                    estado_n = OCIOSO;
                    saida_n  = 2'b00;
                    conf_n   = '0;
                end
            end

            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            estado           <= OCIOSO;
            k                <= '0;
            lin_q            <= '0;
            col_q            <= '0;
            num_q            <= '0;
            tab_q            <= '0;
            saidaNumero      <= '0;
            conflitos        <= '0;
            ocupado          <= 1'b0;
            sudokuAtualizado <= '0;
        end else begin
            estado           <= estado_n;
            k                <= k_n;
            lin_q            <= lin_n;
            col_q            <= col_n;
            num_q            <= num_n;
            tab_q            <= tab_n;
            saidaNumero      <= saida_n;
            conflitos        <= conf_n;
            ocupado          <= ocup_n;
            sudokuAtualizado <= atual_n;
        end
    end

endmodule
